// File: rtl/hidden_neuron_engine_pkg.sv
// Shared sizing, FSM encoding and saturating arithmetic for the hidden-layer neuron engine.
package hidden_neuron_engine_pkg;

  localparam int unsigned N_HIDDEN = 40;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned VOL_W    = 16;
  localparam int unsigned W_W      = 8;
  localparam int unsigned THRESH   = 128;
  localparam int unsigned CNT_W    = 3;

  localparam logic signed [VOL_W-1:0] VOL_MAX  = {1'b0, {(VOL_W-1){1'b1}}};
  localparam logic signed [VOL_W-1:0] VOL_MIN  = {1'b1, {(VOL_W-1){1'b0}}};
  localparam logic signed [VOL_W-1:0] THRESH_S = VOL_W'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Signed add clamped to the representable VOL_W range.
  function automatic logic signed [VOL_W-1:0] sat_add(input logic signed [VOL_W-1:0] a,
                                                      input logic signed [VOL_W-1:0] b);
    logic signed [VOL_W:0] s;
    s = (VOL_W+1)'(a) + (VOL_W+1)'(b);
    if (s[VOL_W] != s[VOL_W-1]) sat_add = s[VOL_W] ? VOL_MIN : VOL_MAX;
    else                        sat_add = $signed(s[VOL_W-1:0]);
  endfunction

endpackage

// File: rtl/hidden_neuron_engine_ram.sv
// Per-neuron membrane voltage and cached synaptic current storage; async read, sync write.
module neuron_state_ram
  import hidden_neuron_engine_pkg::*;
(
  input  logic                    clk,
  input  logic [IDX_W-1:0]        raddr,
  output logic signed [VOL_W-1:0] vol_rdata,
  output logic signed [VOL_W-1:0] cur_rdata,
  input  logic                    vol_we,
  input  logic [IDX_W-1:0]        vol_waddr,
  input  logic signed [VOL_W-1:0] vol_wdata,
  input  logic                    cur_we,
  input  logic [IDX_W-1:0]        cur_waddr,
  input  logic signed [VOL_W-1:0] cur_wdata
);

  logic signed [VOL_W-1:0] vol_mem [N_HIDDEN];
  logic signed [VOL_W-1:0] cur_mem [N_HIDDEN];

  logic raddr_ok;
  assign raddr_ok  = raddr < IDX_W'(N_HIDDEN);
  assign vol_rdata = raddr_ok ? vol_mem[raddr] : '0;
  assign cur_rdata = raddr_ok ? cur_mem[raddr] : '0;

  always_ff @(posedge clk) begin
    if (vol_we && (vol_waddr < IDX_W'(N_HIDDEN))) vol_mem[vol_waddr] <= vol_wdata;
    if (cur_we && (cur_waddr < IDX_W'(N_HIDDEN))) cur_mem[cur_waddr] <= cur_wdata;
  end

endmodule

// File: rtl/hidden_neuron_engine.sv
// Hidden-layer IF neuron datapath: accumulates weighted spikes, fires on threshold,
// caches synaptic current for replay steps and drains per-neuron spike counts.
module hidden_neuron_engine
  import hidden_neuron_engine_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        neuron_idx,
  input  logic                    vol_mem_control,
  input  logic signed [VOL_W-1:0] init_mem_vol,
  input  logic                    load_voltage,
  input  logic                    arithm,
  input  logic                    w_n_a_valid,
  input  logic signed [W_W-1:0]   w_data,
  input  logic                    act_bit,
  input  logic                    export_voltage,
  input  logic                    current_step_finished,
  output logic                    spike_valid,
  output logic [IDX_W-1:0]        spike_idx,
  output logic                    cnt_valid,
  output logic [IDX_W-1:0]        cnt_idx,
  output logic [CNT_W-1:0]        cnt_value,
  output logic                    drain_busy,
  output logic                    protocol_err
);

  state_e                  state_q, state_d;
  logic signed [VOL_W-1:0] acc_q, acc_d, cur_acc_q, cur_acc_d, acc_n, cur_n;
  logic [IDX_W-1:0]        idx_q, idx_d, ptr_q, ptr_d;
  logic [CNT_W-1:0]        spike_cnt [N_HIDDEN];

  logic                    vol_we, cur_we;
  logic [IDX_W-1:0]        vol_waddr, cur_waddr;
  logic signed [VOL_W-1:0] vol_wdata, cur_wdata, vol_rdata, cur_rdata, w_ext;
  logic                    spike_fire, drain_beat, err_set, beat, idx_bad;

  assign w_ext   = VOL_W'(w_data);
  assign idx_bad = (neuron_idx >= IDX_W'(N_HIDDEN)) &&
                   (vol_mem_control || load_voltage || w_n_a_valid || export_voltage);

  neuron_state_ram u_ram (
    .clk       (clk),
    .raddr     (neuron_idx),
    .vol_rdata (vol_rdata),
    .cur_rdata (cur_rdata),
    .vol_we    (vol_we && !rst),
    .vol_waddr (vol_waddr),
    .vol_wdata (vol_wdata),
    .cur_we    (cur_we && !rst),
    .cur_waddr (cur_waddr),
    .cur_wdata (cur_wdata)
  );

  // Next-state, accumulator and memory-port control.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cur_acc_d  = cur_acc_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    acc_n      = acc_q;
    cur_n      = cur_acc_q;
    beat       = 1'b0;
    vol_we     = 1'b0;
    vol_waddr  = neuron_idx;
    vol_wdata  = init_mem_vol;
    cur_we     = 1'b0;
    cur_waddr  = neuron_idx;
    cur_wdata  = '0;
    spike_fire = 1'b0;
    drain_beat = 1'b0;
    err_set    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (idx_bad) begin
          err_set = 1'b1;
        end else begin
          if (vol_mem_control) begin
            vol_we = 1'b1;
            cur_we = 1'b1;
          end
          if (export_voltage || (w_n_a_valid && !load_voltage)) err_set = 1'b1;
          if (load_voltage) begin
            idx_d     = neuron_idx;
            acc_d     = arithm ? sat_add(vol_rdata, cur_rdata) : vol_rdata;
            cur_acc_d = '0;
            state_d   = S_ACC;
          end else if (current_step_finished) begin
            ptr_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end

      S_ACC: begin
        if (idx_bad) begin
          err_set = 1'b1;
        end else begin
          if (load_voltage || current_step_finished) err_set = 1'b1;
          beat = w_n_a_valid && !arithm && act_bit;
          if (beat) begin
            acc_n = sat_add(acc_q, w_ext);
            cur_n = sat_add(cur_acc_q, w_ext);
          end
          acc_d     = acc_n;
          cur_acc_d = cur_n;
          // The export write owns the memory ports; the compare sees this cycle's beat.
          if (export_voltage) begin
            vol_we    = 1'b1;
            vol_waddr = idx_q;
            if (acc_n >= THRESH_S) begin
              vol_wdata  = acc_n - THRESH_S;
              spike_fire = 1'b1;
            end else begin
              vol_wdata = acc_n;
            end
            if (!arithm) begin
              cur_we    = 1'b1;
              cur_waddr = idx_q;
              cur_wdata = cur_n;
            end
            state_d = S_IDLE;
          end else if (vol_mem_control) begin
            vol_we = 1'b1;
            cur_we = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        drain_beat = 1'b1;
        ptr_d      = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(N_HIDDEN - 1)) state_d = S_IDLE;
        if (vol_mem_control && !idx_bad) begin
          vol_we = 1'b1;
          cur_we = 1'b1;
        end
        if (idx_bad || load_voltage || export_voltage || w_n_a_valid || current_step_finished)
          err_set = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cur_acc_q    <= '0;
      idx_q        <= '0;
      ptr_q        <= '0;
      spike_valid  <= 1'b0;
      spike_idx    <= '0;
      cnt_valid    <= 1'b0;
      cnt_idx      <= '0;
      cnt_value    <= '0;
      drain_busy   <= 1'b0;
      protocol_err <= 1'b0;
      for (int unsigned i = 0; i < N_HIDDEN; i++) spike_cnt[i] <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cur_acc_q    <= cur_acc_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      spike_valid  <= spike_fire;
      spike_idx    <= spike_fire ? idx_q : '0;
      cnt_valid    <= drain_beat;
      cnt_idx      <= drain_beat ? ptr_q : '0;
      cnt_value    <= drain_beat ? spike_cnt[ptr_q] : '0;
      drain_busy   <= (state_d == S_DRAIN);
      protocol_err <= protocol_err | err_set;
      if (spike_fire && (spike_cnt[idx_q] != '1))
        spike_cnt[idx_q] <= spike_cnt[idx_q] + CNT_W'(1);
      if (drain_beat) spike_cnt[ptr_q] <= '0;
    end
  end

endmodule

// File: tb/tb_hidden_neuron_engine.sv
// Scoreboard bench for hidden_neuron_engine: directed steps, saturation, drains, errors, resets.
module tb_hidden_neuron_engine;
  import hidden_neuron_engine_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [IDX_W-1:0]        neuron_idx;
  logic                    vol_mem_control;
  logic signed [VOL_W-1:0] init_mem_vol;
  logic                    load_voltage, arithm, w_n_a_valid, act_bit;
  logic signed [W_W-1:0]   w_data;
  logic                    export_voltage, current_step_finished;
  logic                    spike_valid, cnt_valid, drain_busy, protocol_err;
  logic [IDX_W-1:0]        spike_idx, cnt_idx;
  logic [CNT_W-1:0]        cnt_value;

  typedef struct {int idx; int val;} cnt_t;
  int   spike_q [$];
  cnt_t cnt_q [$];
  int   exp_cnt [N_HIDDEN];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hidden_neuron_engine dut (
    .clk(clk), .rst(rst), .neuron_idx(neuron_idx), .vol_mem_control(vol_mem_control),
    .init_mem_vol(init_mem_vol), .load_voltage(load_voltage), .arithm(arithm),
    .w_n_a_valid(w_n_a_valid), .w_data(w_data), .act_bit(act_bit),
    .export_voltage(export_voltage), .current_step_finished(current_step_finished),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .cnt_valid(cnt_valid),
    .cnt_idx(cnt_idx), .cnt_value(cnt_value), .drain_busy(drain_busy),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected output beats whenever the DUT presents one.
  always @(negedge clk) begin
    if (spike_valid === 1'b1) begin
      if (spike_q.size() == 0) chk("spike_unexpected", int'(spike_idx), -1);
      else chk("spike_idx", int'(spike_idx), spike_q.pop_front());
    end
    if (cnt_valid === 1'b1) begin
      if (cnt_q.size() == 0) chk("cnt_unexpected", int'(cnt_idx), -1);
      else begin
        cnt_t e;
        e = cnt_q.pop_front();
        chk("cnt_idx", int'(cnt_idx), e.idx);
        chk("cnt_value", int'(cnt_value), e.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    vol_mem_control = 0; load_voltage = 0; w_n_a_valid = 0; act_bit = 0;
    export_voltage = 0; current_step_finished = 0; w_data = '0;
  endtask

  task automatic init_n(input int idx, input int v);
    neuron_idx = IDX_W'(idx); init_mem_vol = VOL_W'(v); vol_mem_control = 1; cyc(); clear_strobes();
  endtask

  task automatic load_n(input int idx);
    neuron_idx = IDX_W'(idx); load_voltage = 1; cyc(); clear_strobes();
  endtask

  task automatic beat(input int w, input bit a);
    w_n_a_valid = 1; w_data = W_W'(w); act_bit = a; cyc(); clear_strobes();
  endtask

  // Export; the bench decides on its own whether a spike must follow.
  task automatic export_n(input int idx, input bit fires);
    if (fires) begin
      spike_q.push_back(idx);
      if (exp_cnt[idx] < 7) exp_cnt[idx]++;
    end
    export_voltage = 1; cyc(); clear_strobes();
  endtask

  task automatic wait_sb(input string nm);
    for (int k = 0; k < 100 && (cnt_q.size() != 0 || spike_q.size() != 0); k++) cyc();
    chk(nm, cnt_q.size() + spike_q.size(), 0);
  endtask

  task automatic full_drain(input string nm);
    for (int i = 0; i < int'(N_HIDDEN); i++) begin
      cnt_t e;
      e.idx = i; e.val = exp_cnt[i];
      cnt_q.push_back(e);
      exp_cnt[i] = 0;
    end
    current_step_finished = 1; cyc(); clear_strobes();
    chk({nm, "_busy"}, int'(drain_busy), 1);
    wait_sb(nm);
    cyc();
    chk({nm, "_busy_end"}, int'(drain_busy), 0);
    chk({nm, "_state"}, int'(dut.state_q), int'(S_IDLE));
  endtask

  initial begin
    rst = 1; arithm = 0; neuron_idx = '0; init_mem_vol = '0;
    clear_strobes();
    for (int i = 0; i < int'(N_HIDDEN); i++) exp_cnt[i] = 0;
    repeat (3) cyc();
    rst = 0;
    chk("rst_spike_valid", int'(spike_valid), 0);
    chk("rst_cnt_valid", int'(cnt_valid), 0);
    chk("rst_drain_busy", int'(drain_busy), 0);
    chk("rst_err", int'(protocol_err), 0);
    chk("rst_acc", int'(dut.acc_q), 0);

    // Init every neuron to 63, read neurons 0 and 39 back through load+export.
    for (int i = 0; i < int'(N_HIDDEN); i++) init_n(i, 63);
    load_n(0); export_n(0, 0);
    chk("readback_vol0", int'(dut.u_ram.vol_mem[0]), 63);
    chk("readback_cur0", int'(dut.u_ram.cur_mem[0]), 0);
    load_n(39); export_n(39, 0);
    chk("readback_vol39", int'(dut.u_ram.vol_mem[39]), 63);

    // Step 0, neuron 5: 63 + 4*20 = 143 -> spike, residual 15, cached current 80.
    load_n(5);
    repeat (4) beat(20, 1);
    beat(100, 0);
    repeat (3) cyc();
    chk("s0_acc_hold", int'(dut.acc_q), 143);
    export_n(5, 1);
    chk("s0_vol", int'(dut.u_ram.vol_mem[5]), 15);
    chk("s0_cur", int'(dut.u_ram.cur_mem[5]), 80);

    // Step 1 replay: 15 + 80 = 95, beat under replay ignored.
    arithm = 1;
    load_n(5);
    beat(50, 1);
    chk("s1_acc", int'(dut.acc_q), 95);
    export_n(5, 0);
    chk("s1_vol", int'(dut.u_ram.vol_mem[5]), 95);
    chk("s1_cur", int'(dut.u_ram.cur_mem[5]), 80);

    // Step 2 replay with a beat on the load cycle: load wins, 95 + 80 = 175 -> residual 47.
    neuron_idx = 6'd5; load_voltage = 1; w_n_a_valid = 1; w_data = 8'sd10; act_bit = 1;
    cyc(); clear_strobes();
    chk("s2_acc", int'(dut.acc_q), 175);
    export_n(5, 1);
    chk("s2_vol", int'(dut.u_ram.vol_mem[5]), 47);

    // Step 3 replay: 47 + 80 = 127, one below threshold.
    load_n(5);
    chk("s3_acc", int'(dut.acc_q), 127);
    export_n(5, 0);
    chk("s3_vol", int'(dut.u_ram.vol_mem[5]), 127);
    chk("steps_err", int'(protocol_err), 0);
    arithm = 0;

    full_drain("drain1");
    full_drain("drain2");

    // Beat and export together: 63 + 60 + 5 = 128 hits threshold exactly.
    load_n(7);
    repeat (3) beat(20, 1);
    w_n_a_valid = 1; w_data = 8'sd5; act_bit = 1;
    export_n(7, 1);
    chk("thr_vol", int'(dut.u_ram.vol_mem[7]), 0);
    chk("thr_cur", int'(dut.u_ram.cur_mem[7]), 65);

    // Positive and negative saturation.
    init_n(10, 32700);
    load_n(10);
    beat(127, 1);
    chk("sat_pos1", int'(dut.acc_q), 32767);
    beat(127, 1);
    chk("sat_pos2", int'(dut.acc_q), 32767);
    export_n(10, 1);
    chk("sat_pos_vol", int'(dut.u_ram.vol_mem[10]), 32639);
    chk("sat_pos_cur", int'(dut.u_ram.cur_mem[10]), 254);
    init_n(11, -32700);
    load_n(11);
    beat(-128, 1);
    chk("sat_neg1", int'(dut.acc_q), -32768);
    beat(-128, 1);
    chk("sat_neg2", int'(dut.acc_q), -32768);
    export_n(11, 0);
    chk("sat_neg_vol", int'(dut.u_ram.vol_mem[11]), -32768);
    chk("sat_neg_cur", int'(dut.u_ram.cur_mem[11]), -256);
    wait_sb("spikes_done");

    // Reset five beats into a drain: only beats 0..4 may appear.
    for (int i = 0; i < 5; i++) begin
      cnt_t e;
      e.idx = i; e.val = exp_cnt[i];
      cnt_q.push_back(e);
    end
    current_step_finished = 1; cyc(); clear_strobes();
    repeat (5) cyc();
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < int'(N_HIDDEN); i++) exp_cnt[i] = 0;
    chk("rstdrain_q", cnt_q.size(), 0);
    chk("rstdrain_busy", int'(drain_busy), 0);
    chk("rstdrain_cnt_valid", int'(cnt_valid), 0);
    chk("rstdrain_state", int'(dut.state_q), int'(S_IDLE));

    // Reset mid-accumulation.
    load_n(12);
    beat(20, 1);
    rst = 1; cyc(); rst = 0;
    chk("rstacc_acc", int'(dut.acc_q), 0);
    chk("rstacc_state", int'(dut.state_q), int'(S_IDLE));
    chk("rstacc_vol", int'(dut.u_ram.vol_mem[12]), 63);

    full_drain("drain3");

    // Protocol errors.
    load_n(45);
    chk("err_idx45", int'(protocol_err), 1);
    chk("err_idx45_state", int'(dut.state_q), int'(S_IDLE));
    cyc();
    chk("err_sticky", int'(protocol_err), 1);
    rst = 1; cyc(); rst = 0;
    chk("err_rst_clear", int'(protocol_err), 0);
    neuron_idx = '0;
    export_n(0, 0);
    chk("err_export_idle", int'(protocol_err), 1);
    chk("err_export_vol0", int'(dut.u_ram.vol_mem[0]), 63);

    repeat (3) cyc();
    chk("final_spike_q", spike_q.size(), 0);
    chk("final_cnt_q", cnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
